product_accumulator: RTL and testbench

Streaming accumulation stage that sits directly downstream of the multiplier. It takes unsigned 2*WIDTH-bit products under a valid/ready handshake and sums them over a window. A window closes on in_last or after MAX_BEATS products. It then presents the window sum, the beat count and a sticky overflow flag on a registered valid/ready output, and the next window starts accumulating in the same cycle.

---
 rtl/product_acc_pkg.sv | 15 +
 rtl/simple_adder.sv | 15 +
 rtl/product_accumulator.sv | 123 ++++++++++++
 tb/tb_product_accumulator.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/product_acc_pkg.sv
// Shared types and helpers for the product accumulation stage.
package product_acc_pkg;

    // Window state: S_IDLE holds no partial window, S_ACCUM holds one.
    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ACCUM = 1'b1
    } state_t;

    // Default accumulator width for a WIDTH-bit multiplier: product width plus 4 guard bits.
    function automatic int acc_width_default(input int width);
        return 2 * width + 4;
    endfunction

endpackage

// File: rtl/simple_adder.sv
// Plain unsigned WIDTH-bit adder with carry in and carry out.
module simple_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // One extra bit on each operand so the top bit of the result is the carry-out.
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + (WIDTH + 1)'(cin);

endmodule

// File: rtl/product_accumulator.sv
// Streaming window accumulator for unsigned multiplier products.
// A window closes on in_last or after MAX_BEATS beats; its sum, beat count
// and sticky carry-out flag are presented on a registered valid/ready output.
module product_accumulator
    import product_acc_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = acc_width_default(WIDTH),
    parameter int MAX_BEATS = 16,
    parameter int CNT_WIDTH = $clog2(MAX_BEATS + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*WIDTH-1:0]   product,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] acc_out,
    output logic [CNT_WIDTH-1:0] out_count,
    output logic                 overflow
);

    // Partial window state
    logic [ACC_WIDTH-1:0] r_acc;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_ovf;
    state_t               r_state;

    // Output result register
    logic                 r_out_valid;
    logic [ACC_WIDTH-1:0] r_acc_out;
    logic [CNT_WIDTH-1:0] r_out_count;
    logic                 r_overflow;

    logic                 w_accept;
    logic                 w_close;
    logic [CNT_WIDTH-1:0] w_cnt_next;
    logic [ACC_WIDTH-1:0] w_acc_base;
    logic [ACC_WIDTH-1:0] w_product_ext;
    logic [ACC_WIDTH-1:0] w_sum;
    logic                 w_carry;

    // Upstream may push whenever the output slot is empty or being drained this cycle.
    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    assign w_cnt_next = r_cnt + CNT_WIDTH'(1);

    // A beat swallowed by clear never closes a window.
    assign w_close = w_accept && !clear &&
                     (in_last || (w_cnt_next == CNT_WIDTH'(MAX_BEATS)));

    // In S_IDLE the accumulator is zero by construction; starting from zero
    // explicitly keeps the first beat of a window independent of stale state.
    assign w_acc_base    = (r_state == S_ACCUM) ? r_acc : {ACC_WIDTH{1'b0}};
    assign w_product_ext = ACC_WIDTH'(product);

    simple_adder #(
        .WIDTH (ACC_WIDTH)
    ) u_adder (
        .a    (w_acc_base),
        .b    (w_product_ext),
        .cin  (1'b0),
        .sum  (w_sum),
        .cout (w_carry)
    );

    // Window accumulator FSM: clear wins, a closing beat restarts, other beats accumulate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= {ACC_WIDTH{1'b0}};
            r_cnt   <= {CNT_WIDTH{1'b0}};
            r_ovf   <= 1'b0;
            r_state <= S_IDLE;
        end else if (clear) begin
            r_acc   <= {ACC_WIDTH{1'b0}};
            r_cnt   <= {CNT_WIDTH{1'b0}};
            r_ovf   <= 1'b0;
            r_state <= S_IDLE;
        end else if (w_accept) begin
            case (w_close)
                1'b1: begin
                    r_acc   <= {ACC_WIDTH{1'b0}};
                    r_cnt   <= {CNT_WIDTH{1'b0}};
                    r_ovf   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_acc   <= w_sum;
                    r_cnt   <= w_cnt_next;
                    r_ovf   <= r_ovf | w_carry;
                    r_state <= S_ACCUM;
                end
            endcase
        end
    end

    // Result register: load on window close (even while draining), else drop valid on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_acc_out   <= {ACC_WIDTH{1'b0}};
            r_out_count <= {CNT_WIDTH{1'b0}};
            r_overflow  <= 1'b0;
        end else if (w_close) begin
            r_out_valid <= 1'b1;
            r_acc_out   <= w_sum;
            r_out_count <= w_cnt_next;
            r_overflow  <= r_ovf | w_carry;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign acc_out   = r_acc_out;
    assign out_count = r_out_count;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed, table-driven bench for product_accumulator (default and 16-bit accumulator builds).
module tb_product_accumulator;

    logic clk;
    logic rst_n;

    // Default-parameter DUT signals
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] product;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] acc_out;
    logic [4:0]  out_count;
    logic        overflow;

    // ACC_WIDTH=16 DUT signals
    logic        b_clear;
    logic        b_in_valid;
    logic        b_in_ready;
    logic [15:0] b_product;
    logic        b_in_last;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [15:0] b_acc_out;
    logic [4:0]  b_out_count;
    logic        b_overflow;

    int total;
    int bad;

    product_accumulator u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .product   (product),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_out   (acc_out),
        .out_count (out_count),
        .overflow  (overflow)
    );

    product_accumulator #(
        .ACC_WIDTH (16)
    ) u_dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (b_clear),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .product   (b_product),
        .in_last   (b_in_last),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .acc_out   (b_acc_out),
        .out_count (b_out_count),
        .overflow  (b_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [15:0] p;
        logic        last;
        logic        ordy;
        logic        clr;
        logic        e_rdy;
        logic        e_ov;
        logic [19:0] e_acc;
        logic [4:0]  e_cnt;
        logic        e_ovf;
    } vec_t;

    vec_t vecs [18];

    function automatic vec_t mk(input logic v, input logic [15:0] p, input logic last,
                                input logic ordy, input logic clr, input logic e_rdy,
                                input logic e_ov, input logic [19:0] e_acc,
                                input logic [4:0] e_cnt, input logic e_ovf);
        vec_t t;
        t.v = v; t.p = p; t.last = last; t.ordy = ordy; t.clr = clr;
        t.e_rdy = e_rdy; t.e_ov = e_ov; t.e_acc = e_acc; t.e_cnt = e_cnt; t.e_ovf = e_ovf;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] p, input logic last,
                         input logic ordy, input logic clr);
        in_valid = v; product = p; in_last = last; out_ready = ordy; clear = clr;
    endtask

    task automatic drive_b(input logic v, input logic [15:0] p, input logic last,
                           input logic ordy);
        b_in_valid = v; b_product = p; b_in_last = last; b_out_ready = ordy; b_clear = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t t, input int idx);
        drive(t.v, t.p, t.last, t.ordy, t.clr);
        #1;
        chk($sformatf("vec%0d.in_ready", idx), 32'(in_ready), 32'(t.e_rdy));
        tick();
        chk($sformatf("vec%0d.out_valid", idx), 32'(out_valid), 32'(t.e_ov));
        chk($sformatf("vec%0d.acc_out", idx), 32'(acc_out), 32'(t.e_acc));
        chk($sformatf("vec%0d.out_count", idx), 32'(out_count), 32'(t.e_cnt));
        chk($sformatf("vec%0d.overflow", idx), 32'(overflow), 32'(t.e_ovf));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        drive(1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
        drive_b(1'b0, 16'd0, 1'b0, 1'b0);

        //                  v     p        last  ordy  clr   rdy   ov    acc        cnt    ovf
        // Three-beat window closed by in_last
        vecs[0]  = mk(1'b1, 16'd3,   1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 20'd0,  5'd0, 1'b0);
        vecs[1]  = mk(1'b1, 16'd5,   1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 20'd0,  5'd0, 1'b0);
        vecs[2]  = mk(1'b1, 16'd7,   1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 20'd15, 5'd3, 1'b0);
        vecs[3]  = mk(1'b0, 16'd0,   1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 20'd15, 5'd3, 1'b0);
        // Back-pressure: single-beat window held, upstream stalled
        vecs[4]  = mk(1'b1, 16'd10,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 20'd10, 5'd1, 1'b0);
        vecs[5]  = mk(1'b1, 16'd99,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 20'd10, 5'd1, 1'b0);
        vecs[6]  = mk(1'b1, 16'd99,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 20'd10, 5'd1, 1'b0);
        vecs[7]  = mk(1'b1, 16'd99,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 20'd10, 5'd1, 1'b0);
        vecs[8]  = mk(1'b1, 16'd99,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 20'd10, 5'd1, 1'b0);
        vecs[9]  = mk(1'b1, 16'd99,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 20'd10, 5'd1, 1'b0);
        // Drain and close in the same cycle: valid stays high, new result loads
        vecs[10] = mk(1'b1, 16'd4,   1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 20'd4,  5'd1, 1'b0);
        vecs[11] = mk(1'b0, 16'd0,   1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 20'd4,  5'd1, 1'b0);
        // Clear discards 9+9 and the coincident beat 100
        vecs[12] = mk(1'b1, 16'd9,   1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 20'd4,  5'd1, 1'b0);
        vecs[13] = mk(1'b1, 16'd9,   1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 20'd4,  5'd1, 1'b0);
        vecs[14] = mk(1'b1, 16'd100, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 20'd4,  5'd1, 1'b0);
        vecs[15] = mk(1'b1, 16'd2,   1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 20'd2,  5'd1, 1'b0);
        // Clear while a result is pending leaves the result alone
        vecs[16] = mk(1'b0, 16'd0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 20'd2,  5'd1, 1'b0);
        vecs[17] = mk(1'b0, 16'd0,   1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 20'd2,  5'd1, 1'b0);

        // Reset values
        #12;
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.acc_out", 32'(acc_out), 32'd0);
        chk("rst.out_count", 32'(out_count), 32'd0);
        chk("rst.overflow", 32'(overflow), 32'd0);
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst16.out_valid", 32'(b_out_valid), 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 18; i++) begin
            apply(vecs[i], i);
        end

        // Forced close after MAX_BEATS beats of the largest 8x8 product
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, 16'd65025, 1'b0, 1'b1, 1'b0);
            tick();
            chk($sformatf("maxb%0d.out_valid", i), 32'(out_valid), 32'd0);
        end
        drive(1'b1, 16'd65025, 1'b0, 1'b1, 1'b0);
        tick();
        chk("maxb.out_valid", 32'(out_valid), 32'd1);
        chk("maxb.acc_out", 32'(acc_out), 32'd1040400);
        chk("maxb.out_count", 32'(out_count), 32'd16);
        chk("maxb.overflow", 32'(overflow), 32'd0);
        drive(1'b1, 16'd1, 1'b0, 1'b1, 1'b0);
        tick();
        chk("fresh.mid_valid", 32'(out_valid), 32'd0);
        drive(1'b1, 16'd2, 1'b1, 1'b1, 1'b0);
        tick();
        chk("fresh.out_valid", 32'(out_valid), 32'd1);
        chk("fresh.acc_out", 32'(acc_out), 32'd3);
        chk("fresh.out_count", 32'(out_count), 32'd2);
        drive(1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
        tick();
        chk("fresh.drain", 32'(out_valid), 32'd0);

        // 16-bit accumulator: carry-out sets overflow, next window starts clean
        drive_b(1'b1, 16'd65025, 1'b0, 1'b1);
        tick();
        chk("ovf.mid_valid", 32'(b_out_valid), 32'd0);
        drive_b(1'b1, 16'd65025, 1'b1, 1'b1);
        tick();
        chk("ovf.out_valid", 32'(b_out_valid), 32'd1);
        chk("ovf.acc_out", 32'(b_acc_out), 32'd64514);
        chk("ovf.out_count", 32'(b_out_count), 32'd2);
        chk("ovf.overflow", 32'(b_overflow), 32'd1);
        drive_b(1'b1, 16'd5, 1'b1, 1'b1);
        tick();
        chk("ovf2.acc_out", 32'(b_acc_out), 32'd5);
        chk("ovf2.overflow", 32'(b_overflow), 32'd0);
        drive_b(1'b0, 16'd0, 1'b0, 1'b0);
        tick();
        chk("ovf2.held_valid", 32'(b_out_valid), 32'd1);

        // Asynchronous reset mid-window (cnt=4) with a result pending on the 16-bit DUT
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 16'd1, 1'b0, 1'b1, 1'b0);
            tick();
        end
        chk("prerst.out_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("arst.out_valid", 32'(out_valid), 32'd0);
        chk("arst.acc_out", 32'(acc_out), 32'd0);
        chk("arst.out_count", 32'(out_count), 32'd0);
        chk("arst16.out_valid", 32'(b_out_valid), 32'd0);
        chk("arst16.acc_out", 32'(b_acc_out), 32'd0);
        chk("arst16.out_count", 32'(b_out_count), 32'd0);
        drive(1'b1, 16'd1, 1'b1, 1'b1, 1'b0);
        #1;
        rst_n = 1'b1;
        tick();
        chk("postrst.out_valid", 32'(out_valid), 32'd1);
        chk("postrst.acc_out", 32'(acc_out), 32'd1);
        chk("postrst.out_count", 32'(out_count), 32'd1);
        chk("postrst.overflow", 32'(overflow), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
